// File: rtl/pwm_bl_pkg.sv
// pwm_bl_pkg
// Shared definitions for the backlight PWM controller:
//   state_t        - duty-update state machine encoding
//   FADE_DIV_W     - width of the fade divider / step counter
//   inactive_level - output level that means "backlight off"
package pwm_bl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        FADE = 2'd2
    } state_t;

    localparam int FADE_DIV_W = 4;

    // Level driven on the pin when the backlight is off.
    function automatic logic inactive_level(input bit active_high);
        return active_high ? 1'b0 : 1'b1;
    endfunction

endpackage

// File: rtl/pwm_backlight_ctrl_if.sv
// pwm_backlight_ctrl_if
// Host-side bundle of the backlight PWM controller.
//   master : host / register block (drives controls, reads status)
//   slave  : the controller itself
// Controls: enable, prescale, duty_target, duty_load, fade_en, fade_div
// Status  : BackLight_OUT, period_strobe, duty_cur, busy
interface pwm_backlight_ctrl_if #(
    parameter int CNT_W = 8,
    parameter int PRE_W = 8
);
    import pwm_bl_pkg::*;

    logic                  enable;
    logic [PRE_W-1:0]      prescale;
    logic [CNT_W-1:0]      duty_target;
    logic                  duty_load;
    logic                  fade_en;
    logic [FADE_DIV_W-1:0] fade_div;
    logic                  BackLight_OUT;
    logic                  period_strobe;
    logic [CNT_W-1:0]      duty_cur;
    logic                  busy;

    modport master (
        output enable, prescale, duty_target, duty_load, fade_en, fade_div,
        input  BackLight_OUT, period_strobe, duty_cur, busy
    );

    modport slave (
        input  enable, prescale, duty_target, duty_load, fade_en, fade_div,
        output BackLight_OUT, period_strobe, duty_cur, busy
    );

endinterface

// File: rtl/pwm_bl_prescaler.sv
// pwm_bl_prescaler
// Down-counter clock-enable generator: one tick every prescale+1 clocks.
//   CLK, nRST : clock, asynchronous active-low reset
//   enable    : when low the counter is held at 0 and no tick is produced
//   prescale  : reload value
//   tick      : combinational one-clock enable pulse
module pwm_bl_prescaler #(
    parameter int PRE_W = 8
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             enable,
    input  logic [PRE_W-1:0] prescale,
    output logic             tick
);

    logic [PRE_W-1:0] pre_cnt_reg;
    logic [PRE_W-1:0] pre_cnt_next;

    // The counter rests at 0, so the first enabled clock ticks immediately.
    always_comb begin
        tick         = enable && (pre_cnt_reg == '0);
        pre_cnt_next = pre_cnt_reg;
        if (!enable) begin
            pre_cnt_next = '0;
        end else if (tick) begin
            pre_cnt_next = prescale;
        end else begin
            pre_cnt_next = pre_cnt_reg - PRE_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pre_cnt_reg <= '0;
        end else begin
            pre_cnt_reg <= pre_cnt_next;
        end
    end

endmodule

// File: rtl/pwm_backlight_ctrl.sv
// pwm_backlight_ctrl
// LCD backlight PWM generator with prescaler, double-buffered duty and an
// optional linear fade toward a newly loaded duty target.
//   CLK, nRST : clock, asynchronous active-low reset
//   bus       : slave side of pwm_backlight_ctrl_if
//               controls  enable, prescale, duty_target, duty_load,
//                         fade_en, fade_div
//               status    BackLight_OUT (registered), period_strobe,
//                         duty_cur, busy
module pwm_backlight_ctrl
    import pwm_bl_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int PRE_W       = 8,
    parameter bit ACTIVE_HIGH = 1'b1
) (
    input logic                  CLK,
    input logic                  nRST,
    pwm_backlight_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic             OFF_LVL = inactive_level(ACTIVE_HIGH);

    logic                  tick;
    logic                  period_end;
    logic                  pwm_on;
    logic                  load_new_tgt;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [CNT_W-1:0]      tgt_reg;
    logic [CNT_W-1:0]      duty_reg, duty_next;
    logic [FADE_DIV_W-1:0] step_reg, step_next;
    state_t                state_reg, state_next;
    logic                  out_reg;
    logic                  strobe_reg;

    pwm_bl_prescaler #(.PRE_W(PRE_W)) u_prescaler (
        .CLK      (CLK),
        .nRST     (nRST),
        .enable   (bus.enable),
        .prescale (bus.prescale),
        .tick     (tick)
    );

    assign period_end = tick && (cnt_reg == CNT_MAX);

    // Full-scale duty is forced on so that the last count of the period is
    // lit as well (cnt < duty alone would give 255/256).
    assign pwm_on = bus.enable && ((duty_reg == CNT_MAX) || (cnt_reg < duty_reg));

    // A load arriving on the same edge as a boundary update must keep the
    // machine pending, otherwise it would be lost when the old target lands.
    assign load_new_tgt = bus.duty_load && (bus.duty_target != tgt_reg);

    always_comb begin
        cnt_next = cnt_reg;
        if (!bus.enable) begin
            cnt_next = '0;
        end else if (tick) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state_reg;
        duty_next  = duty_reg;
        step_next  = step_reg;
        unique case (state_reg)
            IDLE: begin
                // Loads are accepted while disabled too; they wait in PEND.
                if (bus.duty_load && (bus.duty_target != duty_reg)) begin
                    state_next = PEND;
                end
            end
            PEND: begin
                if (period_end) begin
                    if (bus.fade_en) begin
                        step_next  = '0;
                        state_next = FADE;
                    end else begin
                        duty_next  = tgt_reg;
                        state_next = load_new_tgt ? PEND : IDLE;
                    end
                end
            end
            FADE: begin
                if (period_end) begin
                    if (step_reg == bus.fade_div) begin
                        step_next = '0;
                        // Direction is re-evaluated every step, so a retarget
                        // can reverse the ramp without overshooting.
                        if (duty_reg < tgt_reg) begin
                            duty_next = duty_reg + CNT_W'(1);
                        end else if (duty_reg > tgt_reg) begin
                            duty_next = duty_reg - CNT_W'(1);
                        end
                    end else begin
                        step_next = step_reg + FADE_DIV_W'(1);
                    end
                    if ((duty_next == tgt_reg) && !load_new_tgt) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (!bus.enable) begin
            step_next = '0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            tgt_reg    <= '0;
            duty_reg   <= '0;
            step_reg   <= '0;
            out_reg    <= OFF_LVL;
            strobe_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            duty_reg   <= duty_next;
            step_reg   <= step_next;
            if (bus.duty_load) begin
                tgt_reg <= bus.duty_target;
            end
            out_reg    <= pwm_on ? ~OFF_LVL : OFF_LVL;
            strobe_reg <= period_end;
        end
    end

    assign bus.BackLight_OUT = out_reg;
    assign bus.period_strobe = strobe_reg;
    assign bus.duty_cur      = duty_reg;
    assign bus.busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_pwm_backlight_ctrl.sv
// tb_pwm_backlight_ctrl
// Two controller instances share one set of controls: one active-high, one
// active-low. Stimulus pushes expectations into two queues:
//   imm_q : compared on the next falling edge (pin levels, duty, busy, strobe)
//   per_q : compared when the next period_strobe closes a full PWM period
//           (lit clocks of both instances, period length, duty, busy)
`timescale 1ns/1ps
module tb_pwm_backlight_ctrl;

    localparam int CNT_W = 8;
    localparam int PRE_W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pwm_backlight_ctrl_if #(.CNT_W(CNT_W), .PRE_W(PRE_W)) bus_hi ();
    pwm_backlight_ctrl_if #(.CNT_W(CNT_W), .PRE_W(PRE_W)) bus_lo ();

    assign bus_lo.enable      = bus_hi.enable;
    assign bus_lo.prescale    = bus_hi.prescale;
    assign bus_lo.duty_target = bus_hi.duty_target;
    assign bus_lo.duty_load   = bus_hi.duty_load;
    assign bus_lo.fade_en     = bus_hi.fade_en;
    assign bus_lo.fade_div    = bus_hi.fade_div;

    pwm_backlight_ctrl #(.CNT_W(CNT_W), .PRE_W(PRE_W), .ACTIVE_HIGH(1'b1)) dut_hi (
        .CLK  (clk),
        .nRST (rst_n),
        .bus  (bus_hi)
    );

    pwm_backlight_ctrl #(.CNT_W(CNT_W), .PRE_W(PRE_W), .ACTIVE_HIGH(1'b0)) dut_lo (
        .CLK  (clk),
        .nRST (rst_n),
        .bus  (bus_lo)
    );

    // A negative expected value means "not compared".
    typedef struct {
        string name;
        int    hi;
        int    len;
        int    duty;
        int    busy;
        int    act;
        int    strobe;
    } exp_t;

    exp_t per_q[$];
    exp_t imm_q[$];

    int checks    = 0;
    int errors    = 0;
    int hi_cnt_hi = 0;
    int hi_cnt_lo = 0;
    int cyc_cnt   = 0;
    bit done      = 1'b0;
    bit timed_out = 1'b0;

    function automatic exp_t mk(string n, int hi, int len, int duty, int busy, int act, int strobe);
        exp_t e;
        e.name = n; e.hi = hi; e.len = len; e.duty = duty;
        e.busy = busy; e.act = act; e.strobe = strobe;
        return e;
    endfunction

    function automatic void check(string name, string what, int act, int exp);
        if (exp < 0) return;
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s.%s: got %0d, expected %0d", name, what, act, exp);
        end
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        exp_t e;
        while (imm_q.size() > 0) begin
            e = imm_q.pop_front();
            check(e.name, "out_hi", int'(bus_hi.BackLight_OUT), e.act);
            check(e.name, "out_lo", int'(bus_lo.BackLight_OUT), (e.act < 0) ? -1 : 1 - e.act);
            check(e.name, "duty",   int'(bus_hi.duty_cur), e.duty);
            check(e.name, "duty_lo", int'(bus_lo.duty_cur), e.duty);
            check(e.name, "busy",   int'(bus_hi.busy), e.busy);
            check(e.name, "strobe", int'(bus_hi.period_strobe), e.strobe);
            $display("imm   %-16s out=%0d/%0d duty=%0d busy=%0d strobe=%0d", e.name,
                     bus_hi.BackLight_OUT, bus_lo.BackLight_OUT, bus_hi.duty_cur,
                     bus_hi.busy, bus_hi.period_strobe);
        end
        cyc_cnt++;
        if (bus_hi.BackLight_OUT)  hi_cnt_hi++;
        if (!bus_lo.BackLight_OUT) hi_cnt_lo++;
        if (bus_hi.period_strobe) begin
            if (per_q.size() > 0) begin
                e = per_q.pop_front();
                check(e.name, "lit_hi", hi_cnt_hi, e.hi);
                check(e.name, "lit_lo", hi_cnt_lo, e.hi);
                check(e.name, "len",    cyc_cnt, e.len);
                check(e.name, "duty",   int'(bus_hi.duty_cur), e.duty);
                check(e.name, "busy",   int'(bus_hi.busy), e.busy);
                $display("period %-16s lit=%0d/%0d len=%0d duty=%0d busy=%0d", e.name,
                         hi_cnt_hi, hi_cnt_lo, cyc_cnt, bus_hi.duty_cur, bus_hi.busy);
            end
            hi_cnt_hi = 0;
            hi_cnt_lo = 0;
            cyc_cnt   = 0;
        end
        if (done || timed_out) begin
            check("end", "pending", per_q.size() + imm_q.size(), 0);
            check("end", "watchdog", int'(timed_out), 0);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        #2_000_000;
        timed_out = 1'b1;
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns 1 ns after the edge that raised period_strobe.
    task automatic sync_strobe();
        bit seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = bus_hi.period_strobe;
        end
        if (!seen) imm_q.push_back(mk("strobe_timeout", -1, -1, -1, -1, -1, 1));
    endtask

    task automatic expect_now(input string n, input int act, input int duty, input int busy, input int strobe);
        imm_q.push_back(mk(n, -1, -1, duty, busy, act, strobe));
    endtask

    // Called in a strobe cycle; the expectation covers the period that starts now.
    task automatic push_period(input string n, input int hi, input int len, input int duty, input int busy);
        cycles(1);
        per_q.push_back(mk(n, hi, len, duty, busy, -1, -1));
    endtask

    task automatic next_period(input string n, input int hi, input int len, input int duty, input int busy);
        sync_strobe();
        push_period(n, hi, len, duty, busy);
    endtask

    task automatic load(input int v);
        bus_hi.duty_target = CNT_W'(v);
        bus_hi.duty_load   = 1'b1;
        cycles(1);
        bus_hi.duty_load   = 1'b0;
    endtask

    initial begin
        bus_hi.enable      = 1'b0;
        bus_hi.prescale    = '0;
        bus_hi.duty_target = '0;
        bus_hi.duty_load   = 1'b0;
        bus_hi.fade_en     = 1'b0;
        bus_hi.fade_div    = '0;
        rst_n = 1'b0;
        cycles(3);
        expect_now("reset", 0, 0, 0, 0);
        cycles(1);
        rst_n = 1'b1;
        cycles(2);

        // First load, jump at the period end, 64/256 lit.
        bus_hi.enable = 1'b1;
        load(64);
        expect_now("busy_rise", 0, 0, 1, 0);
        sync_strobe();
        expect_now("first_boundary", 0, 64, 0, 1);
        push_period("jump64_a", 64, 256, 64, 0);
        next_period("jump64_b", 64, 256, 64, 0);

        // Edge duties.
        sync_strobe(); load(0);
        next_period("duty0", 0, 256, 0, 0);
        sync_strobe(); load(255);
        next_period("duty255", 256, 256, 255, 0);

        // Fade 10 -> 13 -> 10, two periods per step.
        sync_strobe(); load(10);
        sync_strobe();
        bus_hi.fade_en  = 1'b1;
        bus_hi.fade_div = 4'd1;
        load(13);
        for (int i = 0; i < 6; i++)
            next_period("fade_up", 10 + i / 2, 256, 10 + (i + 1) / 2, (i < 5) ? 1 : 0);
        sync_strobe(); load(10);
        for (int i = 0; i < 6; i++)
            next_period("fade_down", 13 - i / 2, 256, 13 - (i + 1) / 2, (i < 5) ? 1 : 0);

        // Load coinciding with a period end: old target lands, new one next.
        sync_strobe();
        bus_hi.fade_en = 1'b0;
        load(40);
        cycles(254);
        load(90);
        expect_now("coll_old", 0, 40, 1, 1);
        push_period("coll_new", 40, 256, 90, 0);

        // Retarget mid-fade 20 -> 30, then -> 15 from 23.
        sync_strobe(); load(20);
        sync_strobe();
        bus_hi.fade_en  = 1'b1;
        bus_hi.fade_div = 4'd0;
        load(30);
        for (int i = 0; i < 3; i++)
            next_period("ret_up", 20 + i, 256, 21 + i, 1);
        sync_strobe(); load(15);
        for (int i = 0; i < 8; i++)
            next_period("ret_down", 22 - i, 256, (21 - i < 15) ? 15 : 21 - i, (i < 6) ? 1 : 0);

        // Prescale 3: 1024-clock period, 512 lit clocks at duty 128.
        sync_strobe();
        bus_hi.fade_en  = 1'b0;
        bus_hi.prescale = 8'd3;
        load(128);
        next_period("presc_a", 512, 1024, 128, 0);
        next_period("presc_b", 512, 1024, 128, 0);

        // Disable mid-period, re-enable restarts a full period.
        sync_strobe();
        bus_hi.prescale = 8'd0;
        sync_strobe();
        cycles(10);
        expect_now("pre_disable", 1, 128, 0, 0);
        bus_hi.enable = 1'b0;
        cycles(1);
        expect_now("disabled", 0, 128, 0, 0);
        cycles(20);
        expect_now("still_off", 0, 128, 0, 0);
        bus_hi.enable = 1'b1;
        cycles(255);
        expect_now("restart_mid", 0, 128, 0, 0);
        cycles(1);
        expect_now("restart_end", 0, 128, 0, 1);
        push_period("restart_full", 128, 256, 128, 0);

        // Asynchronous reset in the middle of a fade.
        sync_strobe();
        bus_hi.fade_en  = 1'b1;
        bus_hi.fade_div = 4'd0;
        load(200);
        sync_strobe(); sync_strobe(); sync_strobe();
        expect_now("fade_mid", 0, 130, 1, 1);
        cycles(4);
        expect_now("pre_reset", 1, 130, 1, 0);
        cycles(1);
        #2;
        rst_n = 1'b0;
        expect_now("async_reset", 0, 0, 0, 0);
        cycles(3);
        rst_n = 1'b1;
        cycles(3);
        expect_now("after_reset", 0, 0, 0, 0);

        for (int i = 0; i < 20 && (per_q.size() + imm_q.size()) > 0; i++) cycles(1);
        cycles(1);
        done = 1'b1;
    end

endmodule
